// File: rtl/alu_pkg.sv
// Shared types for the ALU issue stage: opcodes, flag bundle and sequencer states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_DIV = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// REGS x WIDTH register file: two combinational read ports, a debug read port,
// one synchronous write port; entry 0 always reads zero.
module alu_regfile #(
    parameter int WIDTH = 4,
    parameter int REGS  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd2,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd
);

    logic [REGS-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we && (wa != '0))
            mem[wa] <= wd;
    end

    assign rd1      = (ra1      == '0) ? '0 : mem[ra1];
    assign rd2      = (ra2      == '0) ? '0 : mem[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/sequencing stage in front of the combinational ALU: IDLE -> EXEC -> RESP.
// Optional sticky carry/overflow accumulator enabled by ALU_STICKY_FLAGS_EN.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REGS  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             cmd_imm_en,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
`ifdef ALU_STICKY_FLAGS_EN
    ,
    output logic [1:0]       sticky_cv,
    input  logic [0:0]       sticky_clr
`endif
);

    localparam logic [WIDTH:0] SH_LIM = (WIDTH+1)'(WIDTH);

    issue_state_e     state, state_nxt;
    alu_op_e          op_q;
    logic [AW-1:0]    rd_q;
    logic [WIDTH-1:0] rf_rd1, rf_rd2;
    alu_flags_t       flags_q;
    alu_flags_t       alu_flags;
    logic             accept;
    logic             err;
    logic             wr_en;

    assign alu_ctrl  = op_q;
    assign rsp_flags = flags_q;
    assign alu_flags = '{n: alu_negative, z: alu_zero, c: alu_carry, v: alu_overflow};

    // Operand screen: the ALU gives no meaningful result for these.
    assign err   = ((op_q == OP_DIV) && (alu_b == '0)) ||
                   (is_shift(op_q) && ({1'b0, alu_b} >= SH_LIM));
    assign wr_en = (state == EXEC) && !err;

    alu_regfile #(.WIDTH(WIDTH), .REGS(REGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra1      (cmd_rs1),
        .rd1      (rf_rd1),
        .ra2      (cmd_rs2),
        .rd2      (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wr_en),
        .wa       (rd_q),
        .wd       (alu_result)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (cmd_valid)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_ADD;
            rd_q     <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            flags_q  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= alu_op_e'(cmd_op);
                rd_q  <= cmd_rd;
                alu_a <= rf_rd1;
                alu_b <= cmd_imm_en ? cmd_imm : rf_rd2;
            end
            // Response fields only change in EXEC, so they hold through RESP.
            if (state == EXEC) begin
                rsp_err  <= err;
                rsp_data <= err ? '0 : alu_result;
                flags_q  <= err ? '0 : alu_flags;
            end
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst || sticky_clr[0])
            sticky_cv <= 2'b00;
        else if (wr_en)
            sticky_cv <= sticky_cv | {alu_carry, alu_overflow};
    end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed + randomized bench for alu_issue_unit with a behavioural ALU and register-file model.
module tb_alu_issue_unit;

    localparam int W    = 4;
    localparam int REGS = 8;
    localparam int AW   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_imm_en;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2, dbg_addr;
    logic [W-1:0]  cmd_imm, alu_a, alu_b, alu_result, rsp_data, dbg_data;
    logic [2:0]    alu_ctrl;
    logic          alu_negative, alu_zero, alu_carry, alu_overflow;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [3:0]    rsp_flags;
`ifdef ALU_STICKY_FLAGS_EN
    logic [1:0]    sticky_cv;
    logic [0:0]    sticky_clr;
    logic [1:0]    m_sticky;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] m_rf [REGS];

    always #5 clk = ~clk;

    alu_issue_unit #(.WIDTH(W), .REGS(REGS)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_STICKY_FLAGS_EN
        , .sticky_cv(sticky_cv), .sticky_clr(sticky_clr)
`endif
    );

    // Reference ALU: returns {result, N, Z, C, V}.
    function automatic logic [W+3:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi, full;
        logic [W-1:0] r;
        logic c, v;
        ai = int'(a); bi = int'(b); full = 0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin full = ai + bi; r = W'(full); c = full >= (1 << W);
                        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            3'd1: begin r = W'(ai - bi); c = ai < bi;
                        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = (bi == 0) ? '0 : W'(ai / bi);
            3'd5: begin full = ai * bi; r = W'(full); c = full >= (1 << W); v = c; end
            3'd6: r = (bi < W) ? W'(ai << bi) : '0;
            default: r = (bi < W) ? W'(ai >> bi) : '0;
        endcase
        return {r, r[W-1], r == '0, c, v};
    endfunction

    assign {alu_result, alu_negative, alu_zero, alu_carry, alu_overflow} = alu_f(alu_ctrl, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                         input logic [AW-1:0] rs2, input logic imm_en, input logic [W-1:0] imm, input int stall);
        logic [W-1:0] a, b, res;
        logic [3:0]   fl;
        logic         e;
        a = m_rf[rs1];
        b = imm_en ? imm : m_rf[rs2];
        e = (op == 3'd4 && int'(b) == 0) || (op >= 3'd6 && int'(b) >= W);
        {res, fl} = alu_f(op, a, b);
        if (e) begin res = '0; fl = '0; end

        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = imm_en; cmd_imm = imm;
        tick();
        // Garbage on the command bus must be ignored outside IDLE.
        cmd_op = 3'($urandom); cmd_rd = AW'($urandom); cmd_rs1 = AW'($urandom);
        cmd_rs2 = AW'($urandom); cmd_imm = W'($urandom); cmd_imm_en = 1'($urandom);
        check("exec_alu_a", 32'(alu_a), 32'(a));
        check("exec_alu_b", 32'(alu_b), 32'(b));
        check("exec_alu_ctrl", 32'(alu_ctrl), 32'(op));
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_data", 32'(rsp_data), 32'(res));
        check("resp_flags", 32'(rsp_flags), 32'(fl));
        check("resp_err", 32'(rsp_err), 32'(e));
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_data", 32'({rsp_data, rsp_flags, rsp_err}), 32'({res, fl, e}));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_cmd_ready", 32'(cmd_ready), 32'd1);
        if (!e && rd != '0) m_rf[rd] = res;
`ifdef ALU_STICKY_FLAGS_EN
        if (!e) m_sticky = m_sticky | fl[1:0];
        check("sticky_cv", 32'(sticky_cv), 32'(m_sticky));
`endif
        dbg_addr = rd;
        #1;
        check("dbg_rd", 32'(dbg_data), 32'(m_rf[rd]));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0; rsp_ready = 1'b0; dbg_addr = '0;
        for (int i = 0; i < REGS; i++) m_rf[i] = '0;
`ifdef ALU_STICKY_FLAGS_EN
        sticky_clr = 1'b0; m_sticky = 2'b00;
`endif
        tick(); tick();
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_ctrl}), 32'd0);
        check("rst_rsp", 32'({rsp_data, rsp_flags, rsp_err}), 32'd0);
        dbg_addr = 3'd5; #1;
        check("rst_rf5", 32'(dbg_data), 32'd0);

        // Directed sequence
        issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 4'd5, 0);   // ADD r1 = 0 + 5
        issue(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 4'd3, 0);   // r2 = 3
        issue(3'd1, 3'd3, 3'd1, 3'd2, 1'b0, 4'd0, 0);   // SUB r3 = 5 - 3
        issue(3'd4, 3'd6, 3'd1, 3'd0, 1'b1, 4'd0, 0);   // DIV by zero -> err
        issue(3'd6, 3'd6, 3'd1, 3'd0, 1'b1, 4'd4, 0);   // SHL by WIDTH -> err
        issue(3'd7, 3'd6, 3'd1, 3'd0, 1'b1, 4'd9, 0);   // SHR out of range -> err
        issue(3'd6, 3'd7, 3'd1, 3'd0, 1'b1, 4'd1, 0);   // SHL 5 by 1 -> 0xA
        issue(3'd0, 3'd4, 3'd3, 3'd0, 1'b1, 4'd6, 5);   // 5-cycle stall
        issue(3'd0, 3'd0, 3'd1, 3'd2, 1'b0, 4'd0, 1);   // write to r0 discarded
        issue(3'd5, 3'd5, 3'd1, 3'd2, 1'b0, 4'd0, 0);   // MUL 5*3 = 15
        issue(3'd0, 3'd5, 3'd5, 3'd0, 1'b1, 4'd1, 0);   // 0xF + 1 carries

`ifdef ALU_STICKY_FLAGS_EN
        check("sticky_carry_set", 32'(sticky_cv[1]), 32'd1);
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        m_sticky = 2'b00;
        check("sticky_cleared", 32'(sticky_cv), 32'd0);
`endif

        // Reset during EXEC aborts the op and blocks the write.
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 3'd6; cmd_rs1 = 3'd1;
        cmd_imm_en = 1'b1; cmd_imm = 4'd2;
        tick();
        cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rstx_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rstx_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < REGS; i++) m_rf[i] = '0;
`ifdef ALU_STICKY_FLAGS_EN
        m_sticky = 2'b00;
`endif
        dbg_addr = 3'd6; #1;
        check("rstx_rf6", 32'(dbg_data), 32'd0);
        tick();
        check("rstx_still_idle", 32'(rsp_valid), 32'd0);

        // Randomized ops against the model
        for (int n = 0; n < 60; n++) begin
            issue(3'($urandom_range(0, 7)), AW'($urandom), AW'($urandom), AW'($urandom),
                  1'($urandom), W'($urandom), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequencing stage directly upstream of the combinational 3-bit-opcode ALU. Accepts one operation at a time over a valid/ready command interface and reads operands from an internal register file. It drives the ALU operand and control inputs from registers, captures the ALU result and flags, writes the result back, and returns result plus flags over a valid/ready response interface. It also screens operand combinations the ALU cannot handle safely: divide by zero and out-of-range shift amounts.

## Interface
- WIDTH, 4, datapath width; must match the ALU width
- REGS, 8, register-file depth (power of two, ≥2); AW = $clog2(REGS)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted this cycle if also cmd_valid
- cmd_op  in  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 div, 101 mul, 110 shl, 111 shr
- cmd_rd, cmd_rs1, cmd_rs2  in  AW  destination/source register indices
- cmd_imm_en  in  1  operand b taken from cmd_imm instead of rs2
- cmd_imm  in  WIDTH  immediate
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_ctrl  out  3  registered ALU opcode
- alu_result  in  WIDTH  ALU result
- alu_negative, alu_zero, alu_carry, alu_overflow  in  1  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_data  out  WIDTH  result
- rsp_flags  out  4  {N,Z,C,V}
- rsp_err  out  1  operation rejected (no writeback)
- dbg_addr  in  AW; dbg_data  out  WIDTH  combinational register-file read for verification

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: cmd_ready=1. A handshake latches op, rd, a=RF[rs1], and b=(cmd_imm_en ? cmd_imm : RF[rs2]) into alu_a, alu_b and alu_ctrl, then moves to EXEC.
- EXEC: cmd_ready=0. Combinationally:
  - err = (op==100 && b==0) || (op∈{110,111} && b≥WIDTH).
  - If !err: RF[rd] <= alu_result; rsp_data/rsp_flags <= ALU outputs.
  - If err: no write; rsp_data=0, rsp_flags=0, rsp_err=1.
  - Always move to RESP.
- RESP: rsp_valid=1; rsp_data/flags/err held stable until rsp_ready. On rsp_ready, go to IDLE and clear rsp_valid.
- Register 0 reads as zero; writes to it are discarded but the response is still produced.
- Arithmetic is unsigned WIDTH-bit modular as computed by the ALU. This block does no arithmetic other than the err check (b compared as unsigned).
- Read-after-write: the next command reads the value written by the previous one.
- cmd_* inputs are ignored outside IDLE.

## Timing
- Reset: state IDLE; all RF entries 0; alu_a=alu_b=0, alu_ctrl=000; rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0; cmd_ready=1 in the first cycle after reset.
- Command accepted at edge N → EXEC during cycle N+1 → rsp_valid high from N+2.
- Minimum issue interval is 3 cycles: accept, EXEC, RESP with rsp_ready=1, then IDLE.
- rsp_ready held low stalls indefinitely in RESP with outputs stable.
- Reset asserted in any state aborts the operation. No RF write occurs if reset coincides with EXEC, because reset has priority.

## Configuration
- ALU_STICKY_FLAGS_EN defined: adds output sticky_cv [1:0] and input sticky_clr [0:0].
  - Each successful EXEC ORs {C,V} into sticky_cv.
  - sticky_clr clears it; a clear in the same cycle as an EXEC write has priority.
  - Reset value 0.
- ALU_STICKY_FLAGS_EN undefined: ports and register are absent; behaviour is otherwise identical.

## Structure
- Package alu_pkg:
  - alu_op_e enum (the 8 opcodes)
  - alu_flags_t packed struct {n,z,c,v}
  - issue_state_e {IDLE,EXEC,RESP}
- Sub-module alu_regfile:
  - REGS×WIDTH storage
  - two combinational read ports plus the debug read port
  - one synchronous write port
  - r0 hardwired to zero
  - synchronous reset clears all entries

## Test plan
- Reset, then ADD rs1=0 imm=5 rd=1 → rsp_data=5, flags 0000, err=0; dbg RF[1]=5; rsp_valid rises exactly 2 cycles after accept.
- RF[1]=5, RF[2]=3; SUB rd=3 rs1=1 rs2=2 → alu_a=5, alu_b=3, alu_ctrl=001 during EXEC; RF[3]=2 and the response returns the ALU's flags.
- RF[1]=5; DIV rs1=1 imm=0 → rsp_err=1, rsp_data=0, flags 0; RF[rd] unchanged.
- SHL with imm=4 (WIDTH=4) → err=1. SHL RF[1]=5 by imm=1 → rsp_data=0xA, no error.
- Hold rsp_ready=0 for 5 cycles → rsp_valid stays high, data stable, cmd_ready=0. ADD rd=0 → response produced, RF[0] still 0.
- Assert rst during EXEC → next cycle IDLE, rsp_valid=0, RF[rd] not written. With ALU_STICKY_FLAGS_EN, an ADD 0xF+0x1 sets sticky_cv[1] (carry); sticky_clr clears it.
